// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and widths for the MEM/WB write-back stage.
package mem_wb_stage_pkg;

  localparam int MWB_DATA_W = 32;
  localparam int MWB_REG_AW = 5;

  // Write-back source select; WB_RSVD behaves like WB_ALU.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_src_e;

  // Load width/extension; unlisted codes behave like LT_LW.
  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// Sub-word load extraction: picks the addressed byte/halfword of the raw
// memory word and sign- or zero-extends it to the datapath width.
module mem_wb_stage_load_extract
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = MWB_DATA_W
) (
  input  logic [DATA_W-1:0] read_data,
  input  logic [2:0]        load_type,
  input  logic [1:0]        addr_low,
  output logic [DATA_W-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select; addr_low[0] is ignored for halfwords (no alignment trap).
  always_comb begin
    byte_sel = read_data[{addr_low, 3'b000} +: 8];
    half_sel = read_data[{addr_low[1], 4'b0000} +: 16];
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    ext_data = read_data;
    case (load_type)
      LT_LB:   ext_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LT_LH:   ext_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LT_LHU:  ext_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: ext_data = read_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage. Drives the register file
// write port from flops, bypasses the same-cycle write into the ID read
// operands, and counts retired instructions.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = MWB_DATA_W,
  parameter int REG_AW = MWB_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic [1:0]        mem_MemtoReg,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_low,
  input  logic [REG_AW-1:0] mem_Write_register,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  input  logic              wb_stall,
  input  logic              wb_flush,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic              RegWrite,
  output logic [REG_AW-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data,
  output logic              wb_valid,
  output logic [DATA_W-1:0] id_data1,
  output logic [DATA_W-1:0] id_data2,
  output logic [31:0]       retire_count
);

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wb_data_next;
  logic              reg_write_next;

  mem_wb_stage_load_extract #(
    .DATA_W(DATA_W)
  ) u_load_extract (
    .read_data (mem_read_data),
    .load_type (mem_load_type),
    .addr_low  (mem_addr_low),
    .ext_data  (load_data)
  );

  // Write-back source mux and $0 write suppression (register file has no hard-wired $0).
  always_comb begin
    wb_data_next = mem_alu_result;
    case (mem_MemtoReg)
      WB_MEM:  wb_data_next = load_data;
      WB_LINK: wb_data_next = mem_pc_plus4;
      default: wb_data_next = mem_alu_result;
    endcase
    reg_write_next = mem_valid & mem_RegWrite & (mem_Write_register != '0);
  end

  // Pipeline register: reset > flush > stall > load. Flush holds address/data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
      wb_valid       <= 1'b0;
      retire_count   <= '0;
    end else if (wb_flush) begin
      RegWrite <= 1'b0;
      wb_valid <= 1'b0;
    end else if (!wb_stall) begin
      RegWrite       <= reg_write_next;
      Write_register <= mem_Write_register;
      Write_data     <= wb_data_next;
      wb_valid       <= mem_valid;
      if (mem_valid) begin
        retire_count <= retire_count + 32'd1;
      end
    end
  end

  // Write-through bypass: the register file commits at the edge, so a
  // same-cycle ID read would otherwise return the stale value.
  always_comb begin
    id_data1 = rf_data1;
    id_data2 = rf_data2;
    if (RegWrite && (rd_addr1 != '0) && (Write_register == rd_addr1)) begin
      id_data1 = Write_data;
    end
    if (RegWrite && (rd_addr2 != '0) && (Write_register == rd_addr2)) begin
      id_data2 = Write_data;
    end
  end

endmodule
